// File: rtl/idct_inverse_transform.sv
// Inverse 8-point DCT: eight signed coefficients in, eight rounded/saturated samples out.
// Sequential MAC over k (8 cycles) then one rounding cycle; output held until out_ready.
module idct_inverse_transform #(
  parameter int COEF_W = 13,
  parameter int SAMP_W = 8,
  parameter int FRAC   = 12,
  parameter int ACC_W  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] coef_z0,
  input  logic [COEF_W-1:0] coef_z1,
  input  logic [COEF_W-1:0] coef_z2,
  input  logic [COEF_W-1:0] coef_z3,
  input  logic [COEF_W-1:0] coef_z4,
  input  logic [COEF_W-1:0] coef_z5,
  input  logic [COEF_W-1:0] coef_z6,
  input  logic [COEF_W-1:0] coef_z7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SAMP_W-1:0] sample_x0,
  output logic [SAMP_W-1:0] sample_x1,
  output logic [SAMP_W-1:0] sample_x2,
  output logic [SAMP_W-1:0] sample_x3,
  output logic [SAMP_W-1:0] sample_x4,
  output logic [SAMP_W-1:0] sample_x5,
  output logic [SAMP_W-1:0] sample_x6,
  output logic [SAMP_W-1:0] sample_x7
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (SAMP_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);

  // Cosine table in Q12: phase m = (2n+1)k mod 32 folded onto the first quadrant.
  function automatic logic signed [13:0] cos_rom(input logic [2:0] n, input logic [2:0] k);
    logic [6:0]         prod;
    logic [4:0]         m;
    logic [4:0]         idx;
    logic               neg;
    logic signed [13:0] mag;
    prod = 7'({n, 1'b1}) * 7'(k);
    m    = prod[4:0];
    if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
    neg  = (m > 5'd8);
    idx  = neg ? 5'(5'd16 - m) : m;
    case (idx)
      5'd0:    mag = 14'sd2048;
      5'd1:    mag = 14'sd2009;
      5'd2:    mag = 14'sd1892;
      5'd3:    mag = 14'sd1703;
      5'd4:    mag = 14'sd1448;
      5'd5:    mag = 14'sd1138;
      5'd6:    mag = 14'sd784;
      5'd7:    mag = 14'sd400;
      default: mag = 14'sd0;
    endcase
    if (k == 3'd0) return 14'sd1448;
    return neg ? -mag : mag;
  endfunction

  state_t                    state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic signed [COEF_W-1:0]  z_q [8];
  logic signed [COEF_W-1:0]  z_d [8];
  logic signed [ACC_W-1:0]   acc_q [8];
  logic signed [ACC_W-1:0]   acc_d [8];
  logic [SAMP_W-1:0]         samp_q [8];
  logic [SAMP_W-1:0]         samp_d [8];
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [COEF_W-1:0]  coef_in [8];
  logic signed [ACC_W-1:0]   za, ca, prod, rsh;

  always_comb begin
    coef_in[0] = coef_z0; coef_in[1] = coef_z1; coef_in[2] = coef_z2; coef_in[3] = coef_z3;
    coef_in[4] = coef_z4; coef_in[5] = coef_z5; coef_in[6] = coef_z6; coef_in[7] = coef_z7;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    z_d         = z_q;
    acc_d       = acc_q;
    samp_d      = samp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    za          = '0;
    ca          = '0;
    prod        = '0;
    rsh         = '0;
    case (state_q)
      S_IDLE: begin
        if (en && in_valid) begin
          z_d        = coef_in;
          for (int n = 0; n < 8; n++) acc_d[n] = '0;
          k_d        = 3'd0;
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        if (en) begin
          za = ACC_W'(z_q[k_q]);
          for (int n = 0; n < 8; n++) begin
            ca       = ACC_W'(cos_rom(3'(n), k_q));
            prod     = za * ca;
            acc_d[n] = acc_q[n] + prod;
          end
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (en) begin
          for (int n = 0; n < 8; n++) begin
            rsh = (acc_q[n] + HALF) >>> FRAC;
            if (rsh > SMAX)      samp_d[n] = SMAX[SAMP_W-1:0];
            else if (rsh < SMIN) samp_d[n] = SMIN[SAMP_W-1:0];
            else                 samp_d[n] = rsh[SAMP_W-1:0];
          end
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        // Release does not wait for en so a stalled pipeline can still drain.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        z_q[n]    <= '0;
        acc_q[n]  <= '0;
        samp_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sample_x0 = samp_q[0];
  assign sample_x1 = samp_q[1];
  assign sample_x2 = samp_q[2];
  assign sample_x3 = samp_q[3];
  assign sample_x4 = samp_q[4];
  assign sample_x5 = samp_q[5];
  assign sample_x6 = samp_q[6];
  assign sample_x7 = samp_q[7];

endmodule

// File: doc/idct_inverse_transform.md
Name: idct_inverse_transform

Overview:
- Inverse 8-point DCT for the EEG compression datapath; reconstructs eight signed 8-bit samples from eight signed 13-bit integer DCT coefficients, i.e. the integer outputs of the forward DCT transform.
- Sits on the decompression/readback side. Consumes one coefficient block per valid/ready handshake and produces one sample block per valid/ready handshake.
- Uses an 8-cycle sequential multiply-accumulate over coefficient index k, with 8 parallel accumulators.

Parameters:
- COEF_W, 13, width of signed input coefficients.
- SAMP_W, 8, width of signed output samples.
- FRAC, 12, fractional bits of the internal cosine ROM.
- ACC_W, 30, accumulator width (COEF_W + FRAC + 2 + 3).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, FSM and datapath hold state.
- in_valid  in  1  coefficient block valid.
- in_ready  out  1  block can accept coefficients.
- coef_z0..coef_z7  in  COEF_W each  signed coefficients Z[0]..Z[7].
- out_valid  out  1  sample block valid.
- out_ready  in  1  downstream accepts samples.
- sample_x0..sample_x7  out  SAMP_W each  signed reconstructed samples x[0]..x[7].

Behaviour:
- Math: x[n] = sum over k=0..7 of Z[k]·C[n][k].
  - C[n][k] = round(2^FRAC · c(k) · cos((2n+1)kπ/16)).
  - c(0) = sqrt(1/8); c(k>0) = 1/2.
  - ROM values are signed 14-bit, e.g. C[n][0] = 1448, C[0][1] = 2009, C[1][1] = 1703, C[2][1] = 1138, C[3][1] = 400; C[7-n][1] = -C[n][1].
- Rounding: r = (acc + 2^(FRAC-1)) >>> FRAC, an arithmetic shift (round half up).
- Saturation: r is saturated to [-128, 127].
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE: in_ready=1. On en && in_valid, register all Z[k], clear accumulators, set k=0, go to MAC.
  - MAC: in_ready=0. Each en cycle, acc[n] += Z[k]·C[n][k] for all n, then k++. After the k=7 accumulate, go to ROUND.
  - ROUND: on one en cycle, compute rounded/saturated values into the output registers, then go to OUT.
  - OUT: out_valid=1, outputs held stable. On out_ready (independent of en), go to IDLE; out_valid drops the next cycle.
- Latency: 9 en cycles from the accept edge to out_valid=1 (8 MAC + 1 ROUND) with en held high. Minimum block period is 11 cycles.
- No new block is accepted while in MAC, ROUND or OUT. in_ready is high only in IDLE.
- en low:
  - State, k, accumulators and registered Z are frozen.
  - In IDLE, no accept occurs (in_ready is still driven per state).
- Backpressure: in OUT, sample_x* and out_valid hold indefinitely until out_ready. Samples must not change while out_valid=1 && !out_ready.
- Reset (any state, including mid-MAC): state=IDLE, k=0, accumulators=0, sample_x*=0, out_valid=0, in_ready=1 the next cycle. The in-flight block is discarded with no partial output.
- in_valid in a non-IDLE state is ignored; the coefficients are not sampled.
- Accumulator is sized so no overflow is possible for any COEF_W input. Saturation occurs only at the final narrowing.

Test Plan:
- All Z = 0, one handshake -> out_valid after 9 cycles; all sample_x = 0.
- Z0 = 8, others 0 -> every sample_x = 3 (8·1448 + 2048 = 13632, >>12 = 3).
- Z1 = 100, others 0 -> x0..x7 = 49, 42, 28, 10, -10, -28, -42, -49.
- Saturation: Z0 = 362 -> all samples = 127 (raw 128); Z0 = -362 -> all samples = -128.
- Backpressure and stall: hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0, in_valid ignored. Toggle en low for 3 cycles mid-MAC -> out_valid delayed by exactly 3 cycles, values unchanged.
- Reset at k=4 of MAC -> next cycle in_ready=1, out_valid=0, samples 0. A following block (Z0=8) yields all samples 3, with no contamination from the aborted block.
